// File: rtl/block_stream_arbiter.sv
// Round-robin arbiter that shares one coefficient consumer between ROW
// zigzag readout channels. A grant is held for a whole block of BLOCK_LEN
// beats, so blocks from different channels are never interleaved. Each beat
// is tagged with its source channel and start/end-of-block flags.
module block_stream_arbiter #(
    parameter int DATA_WIDTH = 10,
    parameter int ROW        = 3,
    parameter int BLOCK_LEN  = 64,
    parameter int CNT_W      = $clog2(BLOCK_LEN),
    parameter int CH_W       = (ROW > 1) ? $clog2(ROW) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ROW*DATA_WIDTH-1:0] in_data,
    input  logic [ROW-1:0]            in_valid,
    output logic [ROW-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CH_W-1:0]           out_chan,
    output logic                      out_sop,
    output logic                      out_eop,
    output logic                      busy,
    output logic [15:0]               block_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t                state_q,     state_d;
    logic [CH_W-1:0]       grant_q,     grant_d;
    logic [CH_W-1:0]       rr_ptr_q,    rr_ptr_d;
    logic [CNT_W-1:0]      beat_cnt_q,  beat_cnt_d;
    logic [15:0]           block_cnt_q, block_cnt_d;

    logic                  pick_found_s;
    logic [CH_W-1:0]       pick_idx_s;
    logic                  sel_valid_s;
    logic [DATA_WIDTH-1:0] sel_data_s;
    logic                  busy_s;
    logic                  fire_s;
    logic                  last_beat_s;

    // Channel index ptr+off, wrapped modulo ROW.
    function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] ptr, input int off);
        return CH_W'((int'(ptr) + off) % ROW);
    endfunction

    // Channel that follows ch in round-robin order.
    function automatic logic [CH_W-1:0] next_chan(input logic [CH_W-1:0] ch);
        if (ch >= CH_W'(ROW - 1)) begin
            return {CH_W{1'b0}};
        end else begin
            return ch + CH_W'(1);
        end
    endfunction

    // Round-robin pick: first requesting channel scanning from rr_ptr upward.
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = {CH_W{1'b0}};
        for (int i = 0; i < ROW; i++) begin
            if (!pick_found_s && in_valid[wrap_add(rr_ptr_q, i)]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = wrap_add(rr_ptr_q, i);
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Mux the granted channel's valid and data onto the shared path.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_data_s  = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < ROW; i++) begin
            if (grant_q == CH_W'(i)) begin
                sel_valid_s = in_valid[i];
                sel_data_s  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                sel_valid_s = sel_valid_s;
            end
        end
    end

    // Output and handshake decode; zero-latency pass-through while granted.
    always_comb begin
        busy_s      = (state_q == ST_GRANT);
        out_valid   = busy_s & sel_valid_s;
        out_data    = out_valid ? sel_data_s : {DATA_WIDTH{1'b0}};
        out_chan    = busy_s ? grant_q : {CH_W{1'b0}};
        fire_s      = out_valid & out_ready;
        last_beat_s = (beat_cnt_q == CNT_W'(BLOCK_LEN - 1));
        out_sop     = out_valid & (beat_cnt_q == {CNT_W{1'b0}});
        out_eop     = out_valid & last_beat_s;
        busy        = busy_s;
        block_cnt   = block_cnt_q;
        for (int i = 0; i < ROW; i++) begin
            in_ready[i] = busy_s & (grant_q == CH_W'(i)) & out_ready;
        end
    end

    // Next-state logic: arbitrate in IDLE, count beats and release on eop in GRANT.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        block_cnt_d = block_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found_s) begin
                    grant_d = pick_idx_s;
                    state_d = ST_GRANT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (fire_s && last_beat_s) begin
                    beat_cnt_d  = {CNT_W{1'b0}};
                    rr_ptr_d    = next_chan(grant_q);
                    block_cnt_d = block_cnt_q + 16'd1;
                    state_d     = ST_IDLE;
                end else if (fire_s) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end else begin
                    beat_cnt_d = beat_cnt_q;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                beat_cnt_d = {CNT_W{1'b0}};
            end
        endcase
    end

    // State registers; reset abandons any partial block and restarts at channel 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= {CH_W{1'b0}};
            rr_ptr_q    <= {CH_W{1'b0}};
            beat_cnt_q  <= {CNT_W{1'b0}};
            block_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            block_cnt_q <= block_cnt_d;
        end
    end

endmodule
